// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 hex keypad column scanner with per-key debounce and a one-deep
// key-press event register.
//
// One column is driven low at a time for DWELL_CYCLES clocks. On the last clock of each
// dwell the synchronised rows are sampled for that column. Every key runs its own
// debounce counter, and DEBOUNCE_SCANS consecutive differing samples flip its stable
// state. A 0->1 flip raises a press event when none is pending.
//
// Optional feature: define KEYPAD_CHIP8_MAP_EN to present keys/press_idx in CHIP-8 hex
// order instead of raw matrix order (index = row*4 + col).
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   column_pins  column drive, selected column low
//   row_pins     row sense, low = pressed, asynchronous to clk
//   keys         debounced key state, 1 = pressed
//   any_key      OR of keys
//   press_valid  new-press event pending
//   press_idx    index of the pending press
//   press_ack    consumer accepts the pending event
module keypad_scanner #(
  parameter int unsigned DWELL_CYCLES   = 16000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [3:0]  column_pins,
  input  logic [3:0]  row_pins,
  output logic [15:0] keys,
  output logic        any_key,
  output logic        press_valid,
  output logic [3:0]  press_idx,
  input  logic        press_ack
);

  localparam int unsigned DwellW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [DwellW-1:0] DwellLast = DwellW'(DWELL_CYCLES - 1);
  localparam logic [3:0] DebTarget = 4'(DEBOUNCE_SCANS);

  // Output-order index -> matrix index.
  function automatic logic [3:0] map_idx(input logic [3:0] h);
`ifdef KEYPAD_CHIP8_MAP_EN
    logic [3:0] m;
    case (h)
      4'h0:    m = 4'd13;
      4'h1:    m = 4'd0;
      4'h2:    m = 4'd1;
      4'h3:    m = 4'd2;
      4'h4:    m = 4'd4;
      4'h5:    m = 4'd5;
      4'h6:    m = 4'd6;
      4'h7:    m = 4'd8;
      4'h8:    m = 4'd9;
      4'h9:    m = 4'd10;
      4'hA:    m = 4'd12;
      4'hB:    m = 4'd14;
      4'hC:    m = 4'd3;
      4'hD:    m = 4'd7;
      4'hE:    m = 4'd11;
      default: m = 4'd15;
    endcase
    return m;
`else
    return h;
`endif
  endfunction

  logic [3:0]        row_meta_q, row_sync_q;
  logic [DwellW-1:0] dwell_q, dwell_d;
  logic [1:0]        col_q, col_d;
  logic [15:0]       stable_q, stable_d;   // matrix order
  logic [3:0]        cnt_q [16];
  logic [3:0]        cnt_d [16];
  logic              press_valid_q, press_valid_d;
  logic [3:0]        press_idx_q, press_idx_d;

  logic              sample_en;
  logic [15:0]       rise_mat, rise_out;
  logic [3:0]        rise_first;

  // Scan timing and per-key debounce.
  always_comb begin
    sample_en = (dwell_q == DwellLast);
    dwell_d   = sample_en ? '0 : dwell_q + 1'b1;
    col_d     = col_q + {1'b0, sample_en};
    stable_d  = stable_q;
    cnt_d     = cnt_q;
    if (sample_en) begin
      for (int r = 0; r < 4; r++) begin
        if ((~row_sync_q[r]) == stable_q[{2'(r), col_q}]) begin
          cnt_d[{2'(r), col_q}] = '0;
        end else if (cnt_q[{2'(r), col_q}] + 4'd1 == DebTarget) begin
          stable_d[{2'(r), col_q}] = ~row_sync_q[r];
          cnt_d[{2'(r), col_q}]    = '0;
        end else begin
          cnt_d[{2'(r), col_q}] = cnt_q[{2'(r), col_q}] + 4'd1;
        end
      end
    end
  end

  // Press detection; "lowest index" is taken in output order.
  always_comb begin
    rise_mat = stable_d & ~stable_q;
    rise_out = '0;
    keys     = '0;
    for (int h = 0; h < 16; h++) begin
      rise_out[h] = rise_mat[map_idx(4'(h))];
      keys[h]     = stable_q[map_idx(4'(h))];
    end
    rise_first = '0;
    for (int h = 15; h >= 0; h--) begin
      if (rise_out[h]) rise_first = 4'(h);
    end

    press_valid_d = press_valid_q;
    press_idx_d   = press_idx_q;
    if (press_valid_q) begin
      // A press arriving alongside the ack is dropped: clear wins.
      if (press_ack) press_valid_d = 1'b0;
    end else if (|rise_mat) begin
      press_valid_d = 1'b1;
      press_idx_d   = rise_first;
    end
  end

  always_comb begin
    column_pins = ~(4'b0001 << col_q);
    any_key     = |stable_q;
    press_valid = press_valid_q;
    press_idx   = press_idx_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta_q    <= 4'hF;
      row_sync_q    <= 4'hF;
      dwell_q       <= '0;
      col_q         <= '0;
      stable_q      <= '0;
      press_valid_q <= 1'b0;
      press_idx_q   <= '0;
      for (int i = 0; i < 16; i++) cnt_q[i] <= '0;
    end else begin
      row_meta_q    <= row_pins;
      row_sync_q    <= row_meta_q;
      dwell_q       <= dwell_d;
      col_q         <= col_d;
      stable_q      <= stable_d;
      press_valid_q <= press_valid_d;
      press_idx_q   <= press_idx_d;
      for (int i = 0; i < 16; i++) cnt_q[i] <= cnt_d[i];
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a keypad model drives row_pins from a pressed-key
// set, a reference model computes expected keys and press events per full scan, and a
// monitor pops expected press indices whenever press_valid rises.
module tb_keypad_scanner;

  localparam int unsigned Dwell   = 8;
  localparam int unsigned Deb     = 3;
  localparam int unsigned ScanLen = 4 * Dwell;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  column_pins;
  logic [3:0]  row_pins;
  logic [15:0] keys;
  logic        any_key;
  logic        press_valid;
  logic [3:0]  press_idx;
  logic        press_ack = 1'b0;

  logic [15:0] pressed = '0;
  int          checks = 0;
  int          errors = 0;
  logic [3:0]  exp_q [$];
  bit          auto_ack = 1'b0;
  bit          seen = 1'b0;
  bit          has_exp = 1'b0;
  logic [3:0]  cur_exp = '0;

  logic [15:0] m_stable = '0;
  int          m_cnt [16];
  bit          m_pend = 1'b0;

  always #5 clk = ~clk;

  keypad_scanner #(
    .DWELL_CYCLES  (Dwell),
    .DEBOUNCE_SCANS(Deb)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .column_pins(column_pins),
    .row_pins   (row_pins),
    .keys       (keys),
    .any_key    (any_key),
    .press_valid(press_valid),
    .press_idx  (press_idx),
    .press_ack  (press_ack)
  );

  // Physical keypad: a pressed key shorts its row to its column.
  always_comb begin
    row_pins = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !column_pins[c]) row_pins[r] = 1'b0;
  end

  function automatic int hex_to_mat(input int h);
`ifdef KEYPAD_CHIP8_MAP_EN
    int tbl [16] = '{13, 0, 1, 2, 4, 5, 6, 8, 9, 10, 12, 14, 3, 7, 11, 15};
    return tbl[h];
`else
    return h;
`endif
  endfunction

  function automatic logic [15:0] to_out(input logic [15:0] v);
    logic [15:0] o;
    for (int h = 0; h < 16; h++) o[h] = v[hex_to_mat(h)];
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_stable = '0;
    m_pend   = 1'b0;
    for (int i = 0; i < 16; i++) m_cnt[i] = 0;
    exp_q.delete();
  endfunction

  // One full scan with the pressed set held constant: columns sampled 0..3 in order.
  function automatic void model_scan(input logic [15:0] p);
    logic [15:0] rise;
    logic [15:0] ro;
    int          first;
    int          idx;
    for (int c = 0; c < 4; c++) begin
      rise = '0;
      for (int r = 0; r < 4; r++) begin
        idx = r * 4 + c;
        if (p[idx] == m_stable[idx]) begin
          m_cnt[idx] = 0;
        end else begin
          m_cnt[idx]++;
          if (m_cnt[idx] == Deb) begin
            m_stable[idx] = p[idx];
            m_cnt[idx]    = 0;
            if (p[idx]) rise[idx] = 1'b1;
          end
        end
      end
      if (rise != 0 && !m_pend) begin
        ro    = to_out(rise);
        first = 0;
        for (int h = 15; h >= 0; h--) if (ro[h]) first = h;
        exp_q.push_back(4'(first));
        m_pend = !auto_ack;
      end
    end
  endfunction

  // Monitor: pop expected index on each new event, then hold it while pending.
  always @(negedge clk) begin
    if (!rst_n) begin
      seen    = 1'b0;
      has_exp = 1'b0;
    end else if (press_valid) begin
      if (!seen) begin
        seen = 1'b1;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          has_exp = 1'b0;
          $display("FAIL unexpected_event: got press_idx %0h, expected no event at %0t",
                   press_idx, $time);
        end else begin
          cur_exp = exp_q.pop_front();
          has_exp = 1'b1;
        end
        if (auto_ack) press_ack = 1'b1;
      end
      if (has_exp) check("press_idx", {28'd0, press_idx}, {28'd0, cur_exp});
    end else begin
      seen    = 1'b0;
      has_exp = 1'b0;
      if (auto_ack) press_ack = 1'b0;
    end
  end

  // Starts at a scan boundary; ends #1 after the 32nd edge (next boundary).
  task automatic do_scan(input logic [15:0] p, input bit ack);
    pressed = p;
    if (ack) begin
      press_ack = 1'b1;
      m_pend    = 1'b0;
    end
    model_scan(p);
    for (int k = 1; k <= int'(ScanLen); k++) begin
      @(posedge clk);
      #1;
      if (ack && k == 1) press_ack = 1'b0;
      if (k % Dwell == 0)
        check("column_pins", {28'd0, column_pins},
              {28'd0, ~(4'b0001 << ((k / Dwell) % 4))});
    end
    check("keys", {16'd0, keys}, {16'd0, to_out(m_stable)});
    check("any_key", {31'd0, any_key}, {31'd0, |m_stable});
    if (!auto_ack) check("press_valid", {31'd0, press_valid}, {31'd0, m_pend});
  endtask

  task automatic do_reset(input int pre_cycles);
    repeat (pre_cycles) @(posedge clk);
    @(negedge clk);
    rst_n     = 1'b0;
    press_ack = 1'b0;
    model_reset();
    #1;
    check("rst_column_pins", {28'd0, column_pins}, 32'hE);
    check("rst_keys", {16'd0, keys}, 32'h0);
    check("rst_any_key", {31'd0, any_key}, 32'h0);
    check("rst_press_valid", {31'd0, press_valid}, 32'h0);
    check("rst_press_idx", {28'd0, press_idx}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] p;
    int          hold;
    model_reset();
    pressed = '0;
    do_reset(0);

    // Single press of matrix key 6 (row 1, column 2), then release.
    auto_ack = 1'b0;
    repeat (3) do_scan(16'h0040, 1'b0);
`ifndef KEYPAD_CHIP8_MAP_EN
    check("key6_keys", {16'd0, keys}, 32'h0040);
    check("key6_idx", {28'd0, press_idx}, 32'h6);
`endif
    do_scan(16'h0000, 1'b1);
    repeat (2) do_scan(16'h0000, 1'b0);

    // Bounce: two scans present, then gone.
    repeat (2) do_scan(16'h0400, 1'b0);
    repeat (3) do_scan(16'h0000, 1'b0);
    check("bounce_keys", {16'd0, keys}, 32'h0);

    // Keys 5 and 7, then 9 while the event is still pending, then ack.
    repeat (3) do_scan(16'h00A0, 1'b0);
    repeat (3) do_scan(16'h02A0, 1'b0);
`ifndef KEYPAD_CHIP8_MAP_EN
    check("pending_idx", {28'd0, press_idx}, 32'h5);
`endif
    do_scan(16'h02A0, 1'b1);
`ifndef KEYPAD_CHIP8_MAP_EN
    check("after_ack_keys", {16'd0, keys}, 32'h02A0);
`endif
    repeat (3) do_scan(16'h0000, 1'b0);

    // Two keys of one column flip in the same sample.
    do_scan(16'h2002, 1'b1);
    repeat (2) do_scan(16'h2002, 1'b0);
    do_scan(16'h0000, 1'b1);
    repeat (2) do_scan(16'h0000, 1'b0);

    // Reset part-way through debouncing key 3 must discard the progress.
    repeat (2) do_scan(16'h0008, 1'b0);
    do_reset(13);
    repeat (2) do_scan(16'h0008, 1'b0);
    check("rst_debounce_keys", {16'd0, keys}, 32'h0);
    do_scan(16'h0008, 1'b0);
    do_scan(16'h0000, 1'b1);
    repeat (2) do_scan(16'h0000, 1'b0);

`ifdef KEYPAD_CHIP8_MAP_EN
    do_scan(16'h0000, 1'b1);
    repeat (3) do_scan(16'h2000, 1'b0);
    check("chip8_keys", {16'd0, keys}, 32'h0001);
    check("chip8_idx0", {28'd0, press_idx}, 32'h0);
    repeat (3) do_scan(16'h2008, 1'b1);
    check("chip8_idxC", {28'd0, press_idx}, 32'hC);
    do_scan(16'h0000, 1'b1);
    repeat (2) do_scan(16'h0000, 1'b0);
`endif

    // Random patterns, monitor acks every event.
    do_scan(16'h0000, 1'b1);
    auto_ack = 1'b1;
    for (int i = 0; i < 30; i++) begin
      p    = 16'($urandom & $urandom & $urandom);
      hold = $urandom_range(1, 4);
      repeat (hold) do_scan(p, 1'b0);
    end
    repeat (3) do_scan(16'h0000, 1'b0);

    // Random patterns with sparse manual acks, so events get dropped.
    auto_ack = 1'b0;
    for (int i = 0; i < 20; i++) begin
      p    = 16'($urandom & $urandom & $urandom);
      hold = $urandom_range(1, 4);
      for (int j = 0; j < hold; j++) do_scan(p, $urandom_range(0, 2) == 0);
    end
    do_scan(16'h0000, 1'b1);
    repeat (2) do_scan(16'h0000, 1'b0);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
